// File: rtl/sensor_cmd_pkg.sv
// Command/response codes and scheduler state shared by the UART decoder,
// the sensor scheduler and the sensor connection block.
package sensor_cmd_pkg;

   localparam logic [7:0] CMD_READ_TEMP = 8'h01;
   localparam logic [7:0] CMD_READ_HUM  = 8'h02;
   localparam logic [7:0] CMD_LOOP_TEMP = 8'h03;
   localparam logic [7:0] CMD_LOOP_HUM  = 8'h04;
   localparam logic [7:0] CMD_STOP_TEMP = 8'h05;
   localparam logic [7:0] CMD_STOP_HUM  = 8'h06;
   localparam logic [7:0] CMD_RAW       = 8'hAC;

   localparam logic [7:0] RSP_SENSOR_ERR = 8'h07;
   localparam logic [7:0] RSP_SENSOR_OK  = 8'h08;
   localparam logic [7:0] RSP_TEMP       = 8'h09;
   localparam logic [7:0] RSP_LOOP_T_OFF = 8'h0A;
   localparam logic [7:0] RSP_LOOP_H_OFF = 8'h0B;
   localparam logic [7:0] RSP_HUM        = 8'h0C;
   localparam logic [7:0] RSP_LOOP_TEMP  = 8'h0D;
   localparam logic [7:0] RSP_LOOP_HUM   = 8'h0E;
   localparam logic [7:0] RSP_TIMEOUT    = 8'h1F;
   localparam logic [7:0] RSP_INVALID    = 8'h45;
   localparam logic [7:0] RSP_BUSY_LOOP  = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESPOND
   } sched_state_t;

   function automatic logic addr_ok(input logic [7:0] a, input int n);
      return (a != 8'd0) && (int'(a) <= n);
   endfunction

   function automatic logic is_loop_cmd(input logic [7:0] c);
      return (c >= CMD_LOOP_TEMP) && (c <= CMD_STOP_HUM);
   endfunction

endpackage

// File: rtl/rr_next_set.sv
// Finds the lowest set bit at or above a pointer, without wrapping;
// the caller treats "not found" as the end of a sweep.
module rr_next_set #(
   parameter int NUM_SENSORS = 32,
   parameter int PW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
   input  logic [NUM_SENSORS-1:0] i_bits,
   input  logic [PW-1:0]          i_ptr,
   output logic                   o_found,
   output logic [PW-1:0]          o_idx
);

   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
         if (i_bits[i] && (i >= int'(i_ptr))) begin
            o_found = 1'b1;
            o_idx   = PW'(i);
         end
      end
   end

endmodule

// File: rtl/escalonador_sensores.sv
// Arbitrates the shared sensor engine between host one-shot requests and
// the periodic continuous-sensing sweep; buffers one response for the UART.
module escalonador_sensores
   import sensor_cmd_pkg::*;
#(
   parameter int NUM_SENSORS    = 32,
   parameter int GAP_CYCLES     = 100_000_000,
   parameter int TIMEOUT_CYCLES = 5_000_000
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   host_valid,
   output logic                   host_ready,
   input  logic [7:0]             host_command,
   input  logic [7:0]             host_address,
   output logic                   eng_start,
   output logic [7:0]             eng_command,
   output logic [7:0]             eng_address,
   input  logic                   eng_done,
   input  logic [7:0]             eng_resp_command,
   input  logic [7:0]             eng_resp_value,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [7:0]             resp_command,
   output logic [7:0]             resp_value,
   output logic [7:0]             resp_address,
   output logic [NUM_SENSORS-1:0] loop_active
);

   localparam int PW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
   localparam int SW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [PW-1:0] LAST_IDX = PW'(NUM_SENSORS - 1);
   localparam logic [SW-1:0] GAP_LAST = SW'(GAP_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   sched_state_t r_state;
   logic [NUM_SENSORS-1:0] r_loop;
   logic [NUM_SENSORS-1:0] r_kind;
   logic [SW-1:0] r_sweep;
   logic          r_pending;
   logic [PW-1:0] r_rr;
   logic [TW-1:0] r_tmo;
   logic [7:0]    r_code;
   logic          r_eng_start;
   logic [7:0]    r_eng_cmd;
   logic [7:0]    r_eng_addr;
   logic          r_resp_valid;
   logic [7:0]    r_resp_cmd;
   logic [7:0]    r_resp_val;
   logic [7:0]    r_resp_addr;

   logic          w_idle;
   logic          w_haddr_ok;
   logic [PW-1:0] w_hidx;
   logic          w_hloop;
   logic          w_poll;
   logic          w_sweep_wrap;
   logic          w_found;
   logic [PW-1:0] w_idx;
   logic          w_local;
   logic          w_issue;
   logic          w_set_loop;
   logic          w_clr_loop;
   logic          w_kind_hum;
   logic [7:0]    w_lresp;
   logic [7:0]    w_ecmd;
   logic [7:0]    w_eaddr;
   logic [7:0]    w_ecode;

   assign w_idle       = (r_state == ST_IDLE);
   assign w_haddr_ok   = addr_ok(host_address, NUM_SENSORS);
   assign w_hidx       = PW'(host_address - 8'd1);
   assign w_hloop      = r_loop[w_hidx];
   assign w_poll       = w_idle && !host_valid && r_pending;
   assign w_sweep_wrap = (r_sweep == GAP_LAST);

   rr_next_set #(
      .NUM_SENSORS(NUM_SENSORS)
   ) u_rr (
      .i_bits (r_loop),
      .i_ptr  (r_rr),
      .o_found(w_found),
      .o_idx  (w_idx)
   );

   // Host request wins over a pending sweep poll in the same cycle.
   always_comb begin
      w_local    = 1'b0;
      w_issue    = 1'b0;
      w_set_loop = 1'b0;
      w_clr_loop = 1'b0;
      w_kind_hum = 1'b0;
      w_lresp    = '0;
      w_ecmd     = '0;
      w_eaddr    = host_address;
      w_ecode    = '0;
      if (w_idle && host_valid) begin
         if (!w_haddr_ok) begin
            w_local = 1'b1;
            w_lresp = RSP_INVALID;
         end else if (host_command == CMD_STOP_TEMP ||
                      host_command == CMD_STOP_HUM) begin
            w_local    = 1'b1;
            w_clr_loop = 1'b1;
            w_lresp    = (host_command == CMD_STOP_TEMP) ?
                         RSP_LOOP_T_OFF : RSP_LOOP_H_OFF;
         end else if (w_hloop && !is_loop_cmd(host_command)) begin
            w_local = 1'b1;
            w_lresp = RSP_BUSY_LOOP;
         end else if (host_command == CMD_LOOP_TEMP ||
                      host_command == CMD_LOOP_HUM) begin
            w_issue    = 1'b1;
            w_set_loop = 1'b1;
            w_kind_hum = (host_command == CMD_LOOP_HUM);
            w_ecmd     = w_kind_hum ? CMD_READ_HUM : CMD_READ_TEMP;
            w_ecode    = w_kind_hum ? RSP_LOOP_HUM : RSP_LOOP_TEMP;
         end else if (host_command == CMD_READ_TEMP ||
                      host_command == CMD_READ_HUM ||
                      host_command == CMD_RAW) begin
            w_issue = 1'b1;
            w_ecmd  = host_command;
         end else begin
            w_local = 1'b1;
            w_lresp = RSP_INVALID;
         end
      end else if (w_poll && w_found) begin
         w_issue    = 1'b1;
         w_eaddr    = 8'(w_idx) + 8'd1;
         w_kind_hum = r_kind[w_idx];
         w_ecmd     = w_kind_hum ? CMD_READ_HUM : CMD_READ_TEMP;
         w_ecode    = w_kind_hum ? RSP_LOOP_HUM : RSP_LOOP_TEMP;
      end
   end

   // A counter wrap during a sweep just keeps pending set: no queueing.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sweep   <= '0;
         r_pending <= 1'b0;
         r_rr      <= '0;
      end else begin
         r_sweep <= w_sweep_wrap ? '0 : r_sweep + 1'b1;
         if (w_poll) begin
            if (!w_found || w_idx == LAST_IDX)
               r_rr <= '0;
            else
               r_rr <= w_idx + 1'b1;
         end
         if (w_sweep_wrap)
            r_pending <= 1'b1;
         else if (w_poll && (!w_found || w_idx == LAST_IDX))
            r_pending <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_loop       <= '0;
         r_kind       <= '0;
         r_tmo        <= '0;
         r_code       <= '0;
         r_eng_start  <= 1'b0;
         r_eng_cmd    <= '0;
         r_eng_addr   <= '0;
         r_resp_valid <= 1'b0;
         r_resp_cmd   <= '0;
         r_resp_val   <= '0;
         r_resp_addr  <= '0;
      end else begin
         r_eng_start <= 1'b0;
         if (w_set_loop) begin
            r_loop[w_hidx] <= 1'b1;
            r_kind[w_hidx] <= w_kind_hum;
         end
         if (w_clr_loop)
            r_loop[w_hidx] <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_local) begin
                  r_resp_valid <= 1'b1;
                  r_resp_cmd   <= w_lresp;
                  r_resp_val   <= w_lresp;
                  r_resp_addr  <= w_eaddr;
                  r_state      <= ST_RESPOND;
               end else if (w_issue) begin
                  r_eng_start <= 1'b1;
                  r_eng_cmd   <= w_ecmd;
                  r_eng_addr  <= w_eaddr;
                  r_code      <= w_ecode;
                  r_state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_tmo   <= '0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (eng_done) begin
                  r_resp_cmd <= (r_code != 8'h00) ? r_code : eng_resp_command;
                  r_resp_val <= eng_resp_value;
               end else if (r_tmo == TMO_LAST) begin
                  r_resp_cmd <= RSP_TIMEOUT;
                  r_resp_val <= RSP_TIMEOUT;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
               if (eng_done || r_tmo == TMO_LAST) begin
                  r_resp_valid <= 1'b1;
                  r_resp_addr  <= r_eng_addr;
                  r_eng_cmd    <= '0;
                  r_eng_addr   <= '0;
                  r_state      <= ST_RESPOND;
               end
            end
            ST_RESPOND: begin
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_state      <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign host_ready   = w_idle && !reset;
   assign eng_start    = r_eng_start;
   assign eng_command  = r_eng_cmd;
   assign eng_address  = r_eng_addr;
   assign resp_valid   = r_resp_valid;
   assign resp_command = r_resp_cmd;
   assign resp_value   = r_resp_val;
   assign resp_address = r_resp_addr;
   assign loop_active  = r_loop;

endmodule

// File: tb/tb_escalonador_sensores.sv
// Directed bench for the sensor scheduler; the bench plays host, engine
// and transmitter, with short GAP/TIMEOUT values.
module tb_escalonador_sensores;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       host_valid = 1'b0;
   logic [7:0] host_command = '0;
   logic [7:0] host_address = '0;
   logic       eng_done = 1'b0;
   logic [7:0] eng_resp_command = '0;
   logic [7:0] eng_resp_value = '0;
   logic       resp_ready = 1'b0;
   logic        host_ready, eng_start, resp_valid;
   logic [7:0]  eng_command, eng_address;
   logic [7:0]  resp_command, resp_value, resp_address;
   logic [31:0] loop_active;

   int n_chk = 0;
   int n_pass = 0;
   int n_fail = 0;
   int cyc = 0;

   escalonador_sensores #(
      .NUM_SENSORS   (32),
      .GAP_CYCLES    (1000),
      .TIMEOUT_CYCLES(200)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .host_valid      (host_valid),
      .host_ready      (host_ready),
      .host_command    (host_command),
      .host_address    (host_address),
      .eng_start       (eng_start),
      .eng_command     (eng_command),
      .eng_address     (eng_address),
      .eng_done        (eng_done),
      .eng_resp_command(eng_resp_command),
      .eng_resp_value  (eng_resp_value),
      .resp_valid      (resp_valid),
      .resp_ready      (resp_ready),
      .resp_command    (resp_command),
      .resp_value      (resp_value),
      .resp_address    (resp_address),
      .loop_active     (loop_active)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      host_valid = 1'b0;
      eng_done = 1'b0;
      resp_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic send(input logic [7:0] c, input logic [7:0] a);
      host_command = c;
      host_address = a;
      host_valid = 1'b1;
      tick();
      host_valid = 1'b0;
   endtask

   task automatic wait_start(input string tag, input int lim);
      bit ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         if (eng_start) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check(tag, 32'(ok), 32'd1);
   endtask

   task automatic engine(input logic [7:0] rc, input logic [7:0] rv,
                         input int dly);
      repeat (dly) tick();
      eng_resp_command = rc;
      eng_resp_value = rv;
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
   endtask

   task automatic get_resp(input string tag, input logic [7:0] c,
                           input logic [7:0] v, input logic [7:0] a);
      bit ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (resp_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check({tag, "_vld"}, 32'(ok), 32'd1);
      check(tag, {8'h00, resp_command, resp_value, resp_address},
            {8'h00, c, v, a});
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int t1;
      int t2;
      bit stable;

      // reset state, with reset still asserted
      tick();
      tick();
      check("rst_ctl", {29'd0, host_ready, eng_start, resp_valid}, 32'd0);
      check("rst_eng", {16'd0, eng_command, eng_address}, 32'd0);
      check("rst_resp", {8'd0, resp_command, resp_value, resp_address}, 32'd0);
      check("rst_loop", loop_active, 32'd0);
      reset = 1'b0;
      #1;
      check("rdy_after_rst", 32'(host_ready), 32'd1);

      // forwarded read, 40-cycle engine
      send(8'h01, 8'd1);
      check("t1_start", 32'(eng_start), 32'd1);
      check("t1_eng", {16'd0, eng_command, eng_address}, 32'h0101);
      check("t1_busy", 32'(host_ready), 32'd0);
      tick();
      check("t1_pulse", 32'(eng_start), 32'd0);
      repeat (38) tick();
      check("t1_novld", 32'(resp_valid), 32'd0);
      eng_resp_command = 8'h09;
      eng_resp_value = 8'h19;
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      check("t1_lat", 32'(resp_valid), 32'd1);
      get_resp("t1_resp", 8'h09, 8'h19, 8'd1);
      check("t1_idle", {30'd0, host_ready, resp_valid}, 32'b10);

      // invalid addresses answered locally
      send(8'h02, 8'd0);
      check("a0_nostart", 32'(eng_start), 32'd0);
      get_resp("a0", 8'h45, 8'h45, 8'd0);
      send(8'h02, 8'd33);
      check("a33_nostart", 32'(eng_start), 32'd0);
      get_resp("a33", 8'h45, 8'h45, 8'd33);

      // continuous sensing commands
      do_reset();
      send(8'h03, 8'd1);
      check("lt_eng", {16'd0, eng_command, eng_address}, 32'h0101);
      engine(8'h09, 8'h17, 5);
      get_resp("lt", 8'h0D, 8'h17, 8'd1);
      check("lt_loop", loop_active, 32'h1);
      send(8'h01, 8'd1);
      check("busy_nostart", 32'(eng_start), 32'd0);
      get_resp("busy", 8'hFF, 8'hFF, 8'd1);
      send(8'h05, 8'd1);
      get_resp("stop_t", 8'h0A, 8'h0A, 8'd1);
      check("stop_loop", loop_active, 32'h0);
      send(8'h06, 8'd3);
      get_resp("stop_h", 8'h0B, 8'h0B, 8'd3);
      send(8'h07, 8'd2);
      get_resp("unk", 8'h45, 8'h45, 8'd2);
      send(8'hAC, 8'd3);
      check("raw_eng", {16'd0, eng_command, eng_address}, 32'hAC03);
      engine(8'h08, 8'hAA, 2);
      get_resp("raw", 8'h08, 8'hAA, 8'd3);

      // silent engine times out
      do_reset();
      send(8'h01, 8'd7);
      check("to_start", 32'(eng_start), 32'd1);
      n = 0;
      while (!resp_valid && n < 300) begin
         tick();
         n++;
      end
      check("to_lat", n, 32'd201);
      eng_resp_command = 8'h09;
      eng_resp_value = 8'h55;
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      get_resp("to", 8'h1F, 8'h1F, 8'd7);
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      tick();
      check("to_late", {29'd0, host_ready, resp_valid, eng_start}, 32'b100);

      // transmitter stalls for 50 cycles
      do_reset();
      send(8'h02, 8'd4);
      engine(8'h0C, 8'h2A, 3);
      host_command = 8'h01;
      host_address = 8'd3;
      host_valid = 1'b1;
      stable = 1'b1;
      repeat (50) begin
         tick();
         if ({resp_valid, resp_command, resp_value, resp_address} !==
             {1'b1, 8'h0C, 8'h2A, 8'd4} || host_ready || eng_start)
            stable = 1'b0;
      end
      host_valid = 1'b0;
      check("hold_stable", 32'(stable), 32'd1);
      get_resp("hold", 8'h0C, 8'h2A, 8'd4);
      check("hold_idle", {30'd0, host_ready, resp_valid}, 32'b10);

      // reset while waiting on the engine
      do_reset();
      send(8'h04, 8'd6);
      check("lh_eng", {16'd0, eng_command, eng_address}, 32'h0206);
      engine(8'h0C, 8'h33, 2);
      get_resp("lh", 8'h0E, 8'h33, 8'd6);
      check("lh_loop", loop_active, 32'h20);
      send(8'h01, 8'd9);
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("wrst_all", {host_ready, eng_start, resp_valid, eng_command,
            eng_address, resp_command[4:0]}, 32'd0);
      check("wrst_resp", {8'd0, resp_command, resp_value, resp_address}, 32'd0);
      check("wrst_loop", loop_active, 32'd0);
      reset = 1'b0;
      eng_resp_command = 8'h09;
      eng_resp_value = 8'h11;
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      tick();
      check("wrst_late", {29'd0, host_ready, resp_valid, eng_start}, 32'b100);

      // periodic sweep over addresses 2 (temp) and 5 (hum)
      do_reset();
      send(8'h03, 8'd2);
      engine(8'h09, 8'h15, 2);
      get_resp("sw_l2", 8'h0D, 8'h15, 8'd2);
      send(8'h04, 8'd5);
      engine(8'h0C, 8'h40, 2);
      get_resp("sw_l5", 8'h0E, 8'h40, 8'd5);
      check("sw_loop", loop_active, 32'h12);
      wait_start("sw1a_start", 1500);
      t1 = cyc;
      check("sw1a_eng", {16'd0, eng_command, eng_address}, 32'h0102);
      engine(8'h09, 8'h21, 3);
      get_resp("sw1a", 8'h0D, 8'h21, 8'd2);
      wait_start("sw1b_start", 50);
      check("sw1b_eng", {16'd0, eng_command, eng_address}, 32'h0205);
      engine(8'h0C, 8'h22, 3);
      get_resp("sw1b", 8'h0E, 8'h22, 8'd5);
      n = 0;
      repeat (500) begin
         tick();
         if (eng_start) n++;
      end
      check("sw_quiet", n, 32'd0);
      wait_start("sw2a_start", 1500);
      t2 = cyc;
      check("sw2a_eng", {16'd0, eng_command, eng_address}, 32'h0102);
      check("sw_gap", 32'((t2 - t1) >= 1000 && (t2 - t1) <= 1010), 32'd1);
      engine(8'h09, 8'h31, 3);
      get_resp("sw2a", 8'h0D, 8'h31, 8'd2);
      wait_start("sw2b_start", 50);
      check("sw2b_eng", {16'd0, eng_command, eng_address}, 32'h0205);
      engine(8'h0C, 8'h32, 3);
      get_resp("sw2b", 8'h0E, 8'h32, 8'd5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
